// File: rtl/mm_line_burst_reader.sv
// Memory-side line reader: splits one line request into fixed-length bursts on a
// pipelined read port and forwards the returned words as a pixel stream.
module mm_line_burst_reader #(
  parameter int LINE_WORDS = 160,
  parameter int BURST_LEN  = 32,
  parameter int ADDR_W     = 23
) (
  input  logic              xClk,
  input  logic              xReset,
  input  logic              xMemInitDone,
  output logic              xRamReady,
  input  logic              xGbReqRead,
  input  logic [ADDR_W-1:0] xGbAddress,
  output logic              xMemRead,
  output logic [ADDR_W-1:0] xMemAddr,
  output logic [7:0]        xMemBurstCnt,
  input  logic              xMemWaitReq,
  input  logic              xMemRdValid,
  input  logic [15:0]       xMemRdData,
  output logic              xStreamValid,
  output logic [15:0]       xStreamData,
  output logic              xWrBurstDone,
  output logic              xProtoErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LINE_W8  = 8'(LINE_WORDS);
  localparam logic [7:0] BURST_W8 = 8'(BURST_LEN);

  function automatic logic [7:0] burst_words(input logic [7:0] rem);
    return (rem > BURST_W8) ? BURST_W8 : rem;
  endfunction

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [7:0]        cnt_r, cnt_n;
  logic              rd_r, rd_n;
  logic [7:0]        remaining_r, remaining_n;
  logic [7:0]        beats_r, beats_n;
  logic              sv_r, sv_n;
  logic [15:0]       sd_r, sd_n;
  logic              done_r, done_n;
  logic              err_r, err_n;
  logic              ready_r, ready_n;

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    state_n     = state_r;
    addr_n      = addr_r;
    cnt_n       = cnt_r;
    rd_n        = 1'b0;
    remaining_n = remaining_r;
    beats_n     = beats_r;
    sv_n        = 1'b0;
    sd_n        = sd_r;
    done_n      = 1'b0;
    err_n       = err_r | (xGbReqRead & (state_r != IDLE))
                        | (xMemRdValid & (state_r != DATA));
    case (state_r)
      IDLE: begin
        if (xGbReqRead & ready_r) begin
          addr_n      = xGbAddress;
          remaining_n = LINE_W8;
          cnt_n       = burst_words(LINE_W8);
          rd_n        = 1'b1;
          state_n     = CMD;
        end else begin
          state_n = IDLE;
        end
      end
      CMD: begin
        if (~xMemWaitReq) begin
          beats_n = cnt_r;
          state_n = DATA;
        end else begin
          rd_n = 1'b1;
        end
      end
      DATA: begin
        if (xMemRdValid) begin
          sv_n        = 1'b1;
          sd_n        = xMemRdData;
          beats_n     = beats_r - 8'd1;
          remaining_n = remaining_r - 8'd1;
          if (beats_r == 8'd1) begin
            // Address advances by the burst just completed, wrapping at the address width.
            if (remaining_r != 8'd1) begin
              addr_n  = addr_r + ADDR_W'({cnt_r, 1'b0});
              cnt_n   = burst_words(remaining_r - 8'd1);
              rd_n    = 1'b1;
              state_n = CMD;
            end else begin
              state_n = DONE;
            end
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = DATA;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Ready stays low through the done pulse and only rises once idle is settled.
    ready_n = (state_r == IDLE) & (state_n == IDLE) & xMemInitDone;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge xClk) begin
    if (xReset) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      cnt_r       <= 8'd0;
      rd_r        <= 1'b0;
      remaining_r <= 8'd0;
      beats_r     <= 8'd0;
      sv_r        <= 1'b0;
      sd_r        <= 16'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_n;
      addr_r      <= addr_n;
      cnt_r       <= cnt_n;
      rd_r        <= rd_n;
      remaining_r <= remaining_n;
      beats_r     <= beats_n;
      sv_r        <= sv_n;
      sd_r        <= sd_n;
      done_r      <= done_n;
      err_r       <= err_n;
      ready_r     <= ready_n;
    end
  end

  assign xRamReady    = ready_r;
  assign xMemRead     = rd_r;
  assign xMemAddr     = addr_r;
  assign xMemBurstCnt = cnt_r;
  assign xStreamValid = sv_r;
  assign xStreamData  = sd_r;
  assign xWrBurstDone = done_r;
  assign xProtoErr    = err_r;

endmodule

// File: tb/tb_mm_line_burst_reader.sv
// Directed bench: two reader instances (160-word and 100-word lines) driven by a
// burst-returning memory model whose data word equals its word address.
module tb_mm_line_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        init_done, ready, req, mrd, wreq, rdv, sv, done, perr;
  logic [1:0][22:0]  gaddr, maddr;
  logic [1:0][7:0]   mcnt;
  logic [1:0][15:0]  rdd, sd;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pend[2], cmds[2], words[2], dones[2];
  logic [22:0] start[2];
  logic [22:0] rptr[2];
  bit          prev_sv[2], rdy_next[2];
  bit          inj = 1'b0;
  int          stall_cmd = -1;
  int          stall_left = 0;

  mm_line_burst_reader #(.LINE_WORDS(160), .BURST_LEN(32), .ADDR_W(23)) u_dut (
    .xClk(clk), .xReset(rst), .xMemInitDone(init_done[0]), .xRamReady(ready[0]),
    .xGbReqRead(req[0]), .xGbAddress(gaddr[0]), .xMemRead(mrd[0]), .xMemAddr(maddr[0]),
    .xMemBurstCnt(mcnt[0]), .xMemWaitReq(wreq[0]), .xMemRdValid(rdv[0]),
    .xMemRdData(rdd[0]), .xStreamValid(sv[0]), .xStreamData(sd[0]),
    .xWrBurstDone(done[0]), .xProtoErr(perr[0]));

  mm_line_burst_reader #(.LINE_WORDS(100), .BURST_LEN(32), .ADDR_W(23)) u_dut_part (
    .xClk(clk), .xReset(rst), .xMemInitDone(init_done[1]), .xRamReady(ready[1]),
    .xGbReqRead(req[1]), .xGbAddress(gaddr[1]), .xMemRead(mrd[1]), .xMemAddr(maddr[1]),
    .xMemBurstCnt(mcnt[1]), .xMemWaitReq(wreq[1]), .xMemRdValid(rdv[1]),
    .xMemRdData(rdd[1]), .xStreamValid(sv[1]), .xStreamData(sd[1]),
    .xWrBurstDone(done[1]), .xProtoErr(perr[1]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int lw(input int u);
    return (u == 0) ? 160 : 100;
  endfunction

  function automatic logic [22:0] exp_addr(input int u, input int k);
    return start[u] + 23'(64 * k);
  endfunction

  function automatic logic [7:0] exp_cnt(input int u, input int k);
    int r;
    r = lw(u) - 32 * k;
    return 8'((r > 32) ? 32 : r);
  endfunction

  function automatic logic [15:0] exp_word(input int u, input int i);
    logic [22:0] a;
    a = start[u] + 23'(2 * i);
    return a[16:1];
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Memory model and stream monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sv[u] === 1'b1) begin
        check("data", 32'(sd[u]), 32'(exp_word(u, words[u])));
        words[u]++;
      end
      if (rdy_next[u]) begin
        check("rdy_after_done", 32'(ready[u]), 32'd1);
        rdy_next[u] = 1'b0;
      end
      if (done[u] === 1'b1) begin
        check("done_words", 32'(words[u]), 32'(lw(u)));
        check("done_after_last", 32'(prev_sv[u]), 32'd1);
        check("done_excl", 32'(sv[u]), 32'd0);
        check("rdy_at_done", 32'(ready[u]), 32'd0);
        dones[u]++;
        rdy_next[u] = 1'b1;
      end
      prev_sv[u] = (sv[u] === 1'b1);
      if (pend[u] > 0) begin
        rdv[u] = 1'b1;
        rdd[u] = rptr[u][16:1];
        rptr[u] = rptr[u] + 23'd2;
        pend[u]--;
      end else if (u == 0 && inj) begin
        rdv[u] = 1'b1;
        rdd[u] = 16'hBEEF;
      end else begin
        rdv[u] = 1'b0;
      end
      wreq[u] = 1'b0;
      if (mrd[u] === 1'b1) begin
        check("cmd_addr", 32'(maddr[u]), 32'(exp_addr(u, cmds[u])));
        check("cmd_cnt", 32'(mcnt[u]), 32'(exp_cnt(u, cmds[u])));
        if (u == 0 && cmds[0] == stall_cmd && stall_left > 0) begin
          wreq[u] = 1'b1;
          stall_left--;
        end else begin
          pend[u] += int'(mcnt[u]);
          rptr[u] = maddr[u];
          cmds[u]++;
        end
      end
    end
  end

  task automatic do_req(input int u, input logic [22:0] a);
    int t;
    t = 0;
    while (ready[u] !== 1'b1 && t < 50) begin cyc(); t++; end
    check("req_ready", 32'(ready[u]), 32'd1);
    start[u] = a; cmds[u] = 0; words[u] = 0;
    req[u] = 1'b1; gaddr[u] = a;
    cyc();
    req[u] = 1'b0;
    check("rdy_drop", 32'(ready[u]), 32'd0);
  endtask

  task automatic wait_done(input int u);
    int t, d;
    t = 0; d = dones[u];
    while (dones[u] == d && t < 2000) begin cyc(); t++; end
    check("done_seen", 32'(dones[u] - d), 32'd1);
  endtask

  task automatic wait_words(input int u, input int n);
    int t;
    t = 0;
    while (words[u] < n && t < 2000) begin cyc(); t++; end
    check("words_reached", 32'(words[u] >= n), 32'd1);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_rd"}, 32'(mrd[0]), 32'd0);
    check({tag, "_addr"}, 32'(maddr[0]), 32'd0);
    check({tag, "_cnt"}, 32'(mcnt[0]), 32'd0);
    check({tag, "_sv"}, 32'(sv[0]), 32'd0);
    check({tag, "_sd"}, 32'(sd[0]), 32'd0);
    check({tag, "_done"}, 32'(done[0]), 32'd0);
    check({tag, "_err"}, 32'(perr[0]), 32'd0);
    check({tag, "_rdy"}, 32'(ready[0]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int t, d;
    rst = 1'b1; init_done = 2'b11; req = 2'b00; gaddr = '0;
    wreq = 2'b00; rdv = 2'b00; rdd = '0;
    for (int u = 0; u < 2; u++) begin
      pend[u] = 0; cmds[u] = 0; words[u] = 0; dones[u] = 0;
      start[u] = 23'd0; rptr[u] = 23'd0; prev_sv[u] = 1'b0; rdy_next[u] = 1'b0;
    end
    cyc(); cyc();
    reset_check("reset");
    rst = 1'b0;
    cyc();
    check("rdy_after_reset", 32'(ready[0]), 32'd1);

    // Full line without stalls.
    do_req(0, 23'h000100);
    wait_done(0);
    check("l1_cmds", 32'(cmds[0]), 32'd5);
    check("l1_words", 32'(words[0]), 32'd160);
    check("l1_err", 32'(perr[0]), 32'd0);

    // Seven-cycle stall on the third command.
    cyc(); cyc();
    stall_cmd = 2; stall_left = 7;
    do_req(0, 23'h000100);
    wait_done(0);
    check("stall_used", 32'(stall_left), 32'd0);
    check("stall_cmds", 32'(cmds[0]), 32'd5);
    check("stall_words", 32'(words[0]), 32'd160);
    stall_cmd = -1;

    // Partial final burst on the 100-word instance.
    do_req(1, 23'h000000);
    wait_done(1);
    check("part_cmds", 32'(cmds[1]), 32'd4);
    check("part_words", 32'(words[1]), 32'd100);

    // Address wrap, with init-done dropping mid-line.
    cyc(); cyc();
    do_req(0, 23'h7FFFC0);
    init_done[0] = 1'b0;
    repeat (50) cyc();
    init_done[0] = 1'b1;
    wait_done(0);
    check("wrap_cmds", 32'(cmds[0]), 32'd5);
    check("wrap_words", 32'(words[0]), 32'd160);
    check("wrap_err", 32'(perr[0]), 32'd0);

    // Request while busy.
    cyc(); cyc();
    do_req(0, 23'h000100);
    wait_words(0, 10);
    req[0] = 1'b1; gaddr[0] = 23'h005000;
    cyc();
    req[0] = 1'b0;
    cyc();
    check("busy_req_err", 32'(perr[0]), 32'd1);
    wait_done(0);
    check("busy_cmds", 32'(cmds[0]), 32'd5);
    check("busy_words", 32'(words[0]), 32'd160);
    repeat (5) cyc();
    check("err_sticky", 32'(perr[0]), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("err_cleared", 32'(perr[0]), 32'd0);

    // Stray beat while idle.
    cyc(); cyc();
    inj = 1'b1;
    cyc();
    inj = 1'b0;
    cyc();
    check("stray_fwd", 32'(sv[0]), 32'd0);
    check("stray_err", 32'(perr[0]), 32'd1);
    repeat (4) cyc();
    check("stray_sticky", 32'(perr[0]), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;

    // Reset during the second burst's data, then recover.
    cyc(); cyc();
    do_req(0, 23'h000100);
    wait_words(0, 40);
    rst = 1'b1;
    cyc();
    reset_check("abort");
    init_done[0] = 1'b0;
    rst = 1'b0;
    d = dones[0];
    t = 0;
    while (pend[0] > 0 && t < 100) begin cyc(); t++; end
    cyc(); cyc();
    check("abort_stray_err", 32'(perr[0]), 32'd1);
    check("abort_no_done", 32'(dones[0] - d), 32'd0);
    check("abort_rdy_gated", 32'(ready[0]), 32'd0);
    init_done[0] = 1'b1;
    cyc();
    do_req(0, 23'h000100);
    wait_done(0);
    check("recover_cmds", 32'(cmds[0]), 32'd5);
    check("recover_words", 32'(words[0]), 32'd160);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
